i2c_master_arbiter: RTL and testbench
=====================================

Name: i2c_master_arbiter

Overview:
- Shares one I2C_top_module master port among NUM_REQ on-chip requesters using round-robin arbitration.
- Latches the winner's address, direction and write byte, then drives send/r_w/master_address/data_in_1 to the I2C top.
- Waits for tx_done (write) or rx_done (read), then returns a done pulse and read data to the winner.
- Sits between the register/host logic and I2C_top_module.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- SEND_CYCLES, 10: clk cycles send is held high per transaction, ≥1.
- TIMEOUT_CYCLES, 4096: completion wait limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request, one bit per requester.
- req_rw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write.
- req_addr  in  7*NUM_REQ  per-requester 7-bit slave address; requester i uses bits [7i+6:7i].
- req_data  in  8*NUM_REQ  per-requester write byte; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle timeout pulse, coincident with done.
- rd_data  out  8  read byte, valid from the done pulse until the next read completes.
- busy  out  1  high in any state other than IDLE.
- send  out  1  start strobe to the I2C top.
- r_w  out  1  direction to the I2C top.
- master_address  out  7  slave address to the I2C top.
- data_in_1  out  8  write byte to the I2C top.
- tx_done  in  1  write-complete pulse from the I2C top.
- rx_done  in  1  read-complete pulse from the I2C top.
- data_out_master  in  8  read byte from the I2C top.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - gnt, done, err, send, r_w, busy = 0.
  - master_address = 0, data_in_1 = 0, rd_data = 0.
  - Round-robin pointer = 0, so requester 0 has the highest priority first.
- Reset mid-transaction aborts immediately. send drops asynchronously. No done pulse is produced.
- IDLE:
  - If req≠0, pick the first set bit scanning from ptr upward with wrap-around.
  - Latch that requester's req_rw, req_addr and req_data into r_w, master_address and data_in_1.
  - Set the corresponding gnt bit and go to LAUNCH. All of this happens in the same edge.
  - req is sampled only in IDLE.
- LAUNCH:
  - send=1 for exactly SEND_CYCLES cycles, counted by a down-counter, then go to WAIT.
  - The latched operands stay frozen until COMPLETE; later changes on req_* are ignored.
- WAIT:
  - Read: waits for rx_done. Write: waits for tx_done.
  - A completion pulse of the matching type seen during LAUNCH or WAIT is captured in a sticky flag.
  - WAIT exits the cycle after the flag is set, or immediately if it was already set when WAIT is entered.
  - The non-matching done pulse is ignored.
- COMPLETE (one cycle):
  - done[g]=1.
  - If a read: rd_data ← the data_out_master value captured at the rx_done cycle.
  - ptr ← (g+1) mod NUM_REQ.
  - gnt cleared, then go to IDLE.
- Latency:
  - Minimum from IDLE with req high to the done pulse = 1 + SEND_CYCLES + 1 + 1 cycles.
  - Back-to-back transactions have one IDLE cycle between them.
- Deasserting req mid-transaction does not abort; the transaction completes and done still pulses.
- A requester that keeps req high after done is re-arbitrated. Round-robin guarantees every other pending requester is served first.
- Simultaneous requests are resolved only by the pointer; there is no starvation, with worst-case wait NUM_REQ-1 transactions.
- The counter is wide enough for max(SEND_CYCLES, TIMEOUT_CYCLES). It saturates and never wraps.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With it defined:
  - A counter starts at WAIT entry.
  - If no matching completion arrives within TIMEOUT_CYCLES cycles, go to COMPLETE with done[g]=1 and err=1.
  - rd_data is left unchanged on a timeout.
- Without it:
  - WAIT waits indefinitely.
  - err is tied 0 and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Single read:
  - Stimulus: req=4'b0001, req_rw[0]=1, addr0=7'b0101101, data0=8'b10110111; rx_done pulse 50 cycles after send falls with data_out_master=8'hA5.
  - Required: gnt=0001; send high exactly 10 cycles; master_address=2D; done[0] pulses once; rd_data=A5; busy low afterwards.
- Single write:
  - Stimulus: req[2]=1, rw=0, addr=7'h50, data=8'h56; tx_done pulse.
  - Required: data_in_1=56, r_w=0; done[2] pulses; rd_data unchanged; an rx_done injected during WAIT is ignored.
- Round-robin:
  - Stimulus: req=4'b1111 held continuously.
  - Required: grant order 0,1,2,3,0; exactly one IDLE cycle between transactions.
- Early completion:
  - Stimulus: tx_done pulses during LAUNCH cycle 3.
  - Required: done pulses 2 cycles after send falls.
- Reset mid-WAIT:
  - Stimulus: rst=0 for 2 cycles during WAIT.
  - Required: send, gnt, done, busy all 0 immediately; the next grant goes to requester 0.
- Timeout (I2C_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16):
  - Stimulus: a read with no rx_done.
  - Required: done[g] and err pulse together 16 cycles after WAIT entry; rd_data unchanged.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master port among NUM_REQ requesters.
// Optional completion timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SEND_CYCLES    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic                 send,
  output logic                 r_w,
  output logic [6:0]           master_address,
  output logic [7:0]           data_in_1,
  input  logic                 tx_done,
  input  logic                 rx_done,
  input  logic [7:0]           data_out_master
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MaxCnt = (SEND_CYCLES > TIMEOUT_CYCLES) ? SEND_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StComplete} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [7:0]      cap_q, cap_d;
  logic [7:0]      rd_q, rd_d;
  logic            to_q, to_d;

  logic            win_found;
  int unsigned     win_k;
  logic            match;

  // First pending request at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[(32'(ptr_q) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_k     = (32'(ptr_q) + i) % NUM_REQ;
      end
    end
  end

  assign match = rw_q ? rx_done : tx_done;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    cap_d   = cap_q;
    rd_d    = rd_q;
    to_d    = to_q;

    // Sticky completion capture; only the first matching pulse is kept.
    if ((state_q == StLaunch || state_q == StWait) && match && !flag_q) begin
      flag_d = 1'b1;
      if (rw_q) cap_d = data_out_master;
    end

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d   = IdxW'(win_k);
          rw_d    = req_rw[win_k];
          addr_d  = req_addr[7*win_k +: 7];
          wdata_d = req_data[8*win_k +: 8];
          cnt_d   = CntW'(SEND_CYCLES);
          flag_d  = 1'b0;
          to_d    = 1'b0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = CntW'(TIMEOUT_CYCLES);
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        if (flag_q) begin
          if (rw_q) rd_d = cap_q;
          state_d = StComplete;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q <= CntW'(1)) begin
          to_d    = 1'b1;
          state_d = StComplete;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
`endif
      end
      StComplete: begin
        ptr_d   = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      cap_q   <= '0;
      rd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
    end
  end

  // Decoded from the state register so that reset clears them at once.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q != StIdle) gnt = NUM_REQ'(1) << idx_q;
    if (state_q == StComplete) done = NUM_REQ'(1) << idx_q;
  end

  assign err            = (state_q == StComplete) && to_q;
  assign busy           = (state_q != StIdle);
  assign send           = (state_q == StLaunch);
  assign r_w            = rw_q;
  assign master_address = addr_q;
  assign data_in_1      = wdata_q;
  assign rd_data        = rd_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed plus randomized bench for i2c_master_arbiter against a transaction-level model.
module tb_i2c_master_arbiter;
  localparam int N    = 4;
  localparam int SEND = 10;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_rw;
  logic [7*N-1:0]  req_addr;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    gnt, done;
  logic            err, busy, send, r_w;
  logic [7:0]      rd_data, data_in_1, data_out_master;
  logic [6:0]      master_address;
  logic            tx_done, rx_done;

  i2c_master_arbiter #(
    .NUM_REQ       (N),
    .SEND_CYCLES   (SEND),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .gnt            (gnt),
    .done           (done),
    .err            (err),
    .rd_data        (rd_data),
    .busy           (busy),
    .send           (send),
    .r_w            (r_w),
    .master_address (master_address),
    .data_in_1      (data_in_1),
    .tx_done        (tx_done),
    .rx_done        (rx_done),
    .data_out_master(data_out_master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int         m_ptr;
  logic [7:0] m_rd;
  int         w;
  logic       exp_rw;
  logic [6:0] exp_addr;
  logic [7:0] exp_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  // Called in an IDLE cycle; returns at LAUNCH cycle 1 after checking the grant.
  task automatic start_txn(input logic [N-1:0] r, input logic [N-1:0] rw,
                           input logic [7*N-1:0] a, input logic [8*N-1:0] d, input bit hold);
    req      = r;
    req_rw   = rw;
    req_addr = a;
    req_data = d;
    w        = pick(r, m_ptr);
    exp_rw   = rw[w];
    exp_addr = a[7*w +: 7];
    exp_data = d[8*w +: 8];
    step();
    check("grant", 32'(gnt), 32'(1) << w);
    check("grant_addr", 32'(master_address), 32'(exp_addr));
    check("grant_wdata", 32'(data_in_1), 32'(exp_data));
    check("grant_rw", 32'(r_w), 32'(exp_rw));
    check("grant_busy", 32'(busy), 32'd1);
    if (!hold) begin
      req      = '0;
      req_rw   = ~rw;
      req_addr = ~a;
      req_data = ~d;
    end
  endtask

  // p: cycle of the matching completion pulse (0 = none); q: cycle of a wrong-type pulse.
  task automatic run_txn(input int p, input int q, input logic [7:0] pdata);
    int  n     = 1;
    int  sends = 0;
    int  dn    = 0;
    bit  seen  = 0;
    int  exp_n;
    logic [7:0] exp_rd;
    exp_n  = (p == 0) ? SEND + 1 + TO : ((p > SEND) ? p : SEND) + 2;
    exp_rd = (exp_rw && p != 0) ? pdata : m_rd;
    while (!seen && n <= 300) begin
      if (send) sends++;
      if (done !== '0) begin
        seen = 1;
        dn   = n;
        check("done_vec", 32'(done), 32'(1) << w);
        check("done_gnt", 32'(gnt), 32'(1) << w);
        check("done_err", 32'(err), (p == 0) ? 32'd1 : 32'd0);
        check("done_rd_data", 32'(rd_data), 32'(exp_rd));
        check("frozen_addr", 32'(master_address), 32'(exp_addr));
        check("frozen_wdata", 32'(data_in_1), 32'(exp_data));
        tx_done = 1'b0;
        rx_done = 1'b0;
      end else begin
        tx_done         = (n == p && !exp_rw) || (n == q && exp_rw);
        rx_done         = (n == p && exp_rw) || (n == q && !exp_rw);
        data_out_master = (n == p) ? pdata : ~pdata;
        step();
        n++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(dn), 32'(exp_n));
    check("send_cycles", 32'(sends), 32'(SEND));
    m_ptr = (w + 1) % N;
    m_rd  = exp_rd;
    step();
    check("post_done", 32'(done), 32'd0);
    check("post_err", 32'(err), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_gnt", 32'(gnt), 32'd0);
    check("post_rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  initial begin
    logic [N-1:0] r, rw;
    int           p, q;
    rst             = 1'b1;
    req             = '0;
    req_rw          = '0;
    req_addr        = '0;
    req_data        = '0;
    tx_done         = 1'b0;
    rx_done         = 1'b0;
    data_out_master = '0;
    m_ptr           = 0;
    m_rd            = '0;
    #1 rst = 1'b0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_send", 32'(send), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rw", 32'(r_w), 32'd0);
    check("rst_addr", 32'(master_address), 32'd0);
    check("rst_wdata", 32'(data_in_1), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    step();

    // Single read with completion 50 cycles after send falls
    start_txn(4'b0001, 4'b0001, 28'h000002D, 32'h000000B7, 1'b0);
    run_txn(SEND + 50, 0, 8'hA5);

    // Single write on requester 2 with a stray rx_done in WAIT
    start_txn(4'b0100, 4'b0000, 28'h50 << 14, 32'h56 << 16, 1'b0);
    run_txn(20, SEND + 3, 8'h3C);

    // Early completion during LAUNCH cycle 3
    start_txn(4'b1000, 4'b0000, 28'($urandom), $urandom, 1'b0);
    run_txn(3, 0, 8'h00);

    // Reset in WAIT aborts immediately
    start_txn(4'b0010, 4'b0010, 28'($urandom), $urandom, 1'b0);
    for (int i = 0; i < SEND + 3; i++) step();
    check("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_send", 32'(send), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    step();
    rst   = 1'b1;
    m_ptr = 0;
    m_rd  = '0;
    step();

    // Round robin with all requests held
    for (int t = 0; t < 5; t++) begin
      start_txn(4'b1111, 4'($urandom), 28'($urandom), $urandom, 1'b1);
      check("rr_order", 32'(w), 32'(t % N));
      run_txn($urandom_range(1, 2 * SEND), 0, 8'($urandom));
    end
    req = '0;
    step();

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      r  = 4'($urandom_range(1, 15));
      rw = 4'($urandom);
      p  = $urandom_range(1, 3 * SEND);
      q  = $urandom_range(1, 3 * SEND);
      if (q == p) q = 0;
      start_txn(r, rw, 28'($urandom), $urandom, 1'b0);
      run_txn(p, q, 8'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Read with no completion times out
    start_txn(4'b0100, 4'b0100, 28'($urandom), $urandom, 1'b0);
    run_txn(0, 0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
